configurable_transmitter: RTL and testbench
===========================================

CONFIGURABLE_TRANSMITTER -- requirements
Module: configurable_transmitter

Interface
REQ-001 CLOCKS_PER_BIT, default 868, clock cycles per serial bit period; legal >= 2.
REQ-002 DATA_BITS, default 8, data bits per frame; legal 5..9.
REQ-003 PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-004 STOP_BITS, default 1, stop bits per frame; legal 1 or 2.
REQ-005 FIFO_DEPTH, default 4, buffered words; power of 2, >= 2.
REQ-006 Any illegal parameter value SHALL stop elaboration with an error.
REQ-007 clock  input  1  sole clock, rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 tx_valid  input  1  tx_data is offered this cycle.
REQ-010 tx_data  input  DATA_BITS  word to send, LSB first.
REQ-011 tx_ready  output  1  FIFO can accept a word this cycle.
REQ-012 serial  output  1  registered serial line, idle high.
REQ-013 tx_busy  output  1  frame in progress or FIFO non-empty.
REQ-014 tx_done  output  1  one-cycle pulse per completed frame.

Function
REQ-015 A word SHALL be accepted on a rising edge where tx_valid && tx_ready; tx_data is sampled only then.
REQ-016 tx_ready SHALL be !full && !reset, independent of tx_valid and of a same-cycle pop (full FIFO never accepts, even while popping).
REQ-017 Words SHALL be transmitted in acceptance order; none dropped or duplicated.
REQ-018 States IDLE, START, DATA, PARITY, STOP; encoding fixed in the shared package.
REQ-019 IDLE with FIFO non-empty: next edge pops head into shift register, enters START, drives serial 0; a word accepted at edge N into an empty FIFO in IDLE drives serial low at edge N+1.
REQ-020 Every bit SHALL last exactly CLOCKS_PER_BIT cycles; counter runs 0..CLOCKS_PER_BIT-1, width $clog2(CLOCKS_PER_BIT).
REQ-021 DATA sends DATA_BITS bits, LSB first; bit index wraps to 0 on leaving DATA.
REQ-022 PARITY state is skipped when PARITY=0; odd: ones count over data+parity odd; even: that count even.
REQ-023 STOP drives serial 1 for STOP_BITS*CLOCKS_PER_BIT cycles.
REQ-024 At end of STOP: FIFO non-empty -> pop and enter START on the same edge (zero idle cycles between frames); else enter IDLE.
REQ-025 tx_done SHALL be high for exactly the one cycle following the edge that ends STOP.
REQ-026 Frame length SHALL be (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLOCKS_PER_BIT cycles.
REQ-027 tx_busy SHALL be low iff state is IDLE and FIFO is empty.

Reset
REQ-028 While reset is high: serial=1, tx_ready=0, tx_busy=0, tx_done=0, state IDLE, counters 0, FIFO empty.
REQ-029 Reset mid-frame SHALL abort the frame immediately (asynchronously), discard FIFO contents, emit no tx_done.
REQ-030 The first edge after reset deassertion SHALL be able to accept a word.

Structure
REQ-031 Shared package uart_pkg holds state encodings and parity-mode constants (PARITY_NONE, PARITY_ODD, PARITY_EVEN).
REQ-032 Buffer SHALL be a separate sub-module tx_fifo (DATA_BITS wide, FIFO_DEPTH deep, count-based full/empty, pointer wrap at depth).

Verification (CLOCKS_PER_BIT=4 unless stated)
REQ-033 Defaults, push 0xA5 -> serial 0 x4, then 1,0,1,0,0,1,0,1 x4 each, 1 x4; 40-cycle frame; single tx_done pulse.
REQ-034 DATA_BITS=7, PARITY=2, STOP_BITS=2, push 0x55 -> parity bit 0, 44-cycle frame; same with PARITY=1 -> parity bit 1.
REQ-035 FIFO_DEPTH=4, tx_valid held with 6 words -> 5 accepted on first 5 edges, tx_ready low until next pop, 6 back-to-back frames with no idle gap, 6 tx_done pulses.
REQ-036 Reset asserted during DATA bit 3 with 2 words queued -> serial 1 and tx_busy 0 before next edge, no tx_done; after release push 0x3C -> clean 0x3C frame only.
REQ-037 tx_data changed after acceptance and while tx_valid low -> transmitted value equals accepted value.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the configurable serial transmitter:
//                frame state encoding, parity mode constants and a parity
//                helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Frame state encoding shared by every user of the transmitter.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // Parity modes.
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Widest supported data word; the parity helper works on this width.
  localparam int MAX_DATA_BITS = 9;

  // Parity bit that makes (data ones + parity bit) odd or even.
  // Unused upper data bits must be zero.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                      input int                        mode);
    logic x;
    x = ^data;
    parity_bit = (mode == PARITY_ODD) ? ~x : x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tx_fifo
//  Description : Count-based synchronous FIFO feeding the transmitter.
//                Head word is visible combinationally on o_data.
//  Ports       : i_clk    - clock, rising edge
//                i_rst    - asynchronous active-high reset (empties FIFO)
//                i_push   - write i_data (ignored when full)
//                i_data   - word to write
//                i_pop    - discard head word (ignored when empty)
//                o_data   - head word
//                o_full   - DEPTH words stored
//                o_empty  - no words stored
//  Revision    : 1.0 - initial release
// ============================================================================
module tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr];

  // Storage needs no reset: validity is tracked entirely by r_count.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/configurable_transmitter.sv
`default_nettype none
// ============================================================================
//  Module      : configurable_transmitter
//  Description : Asynchronous serial transmitter with configurable bit time,
//                data width, parity and stop bits, fed by a small FIFO.
//                Frames are sent back to back while words are queued.
//  Ports       : i_clk      - sole clock, rising edge
//                i_rst      - asynchronous active-high reset
//                i_tx_valid - i_tx_data offered this cycle
//                i_tx_data  - word to send, LSB first
//                o_tx_ready - FIFO can accept a word this cycle
//                o_serial   - registered serial line, idle high
//                o_tx_busy  - frame in progress or FIFO non-empty
//                o_tx_done  - one-cycle pulse per completed frame
//  Revision    : 1.0 - initial release
// ============================================================================
module configurable_transmitter
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 868,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_tx_valid,
  input  logic [DATA_BITS-1:0] i_tx_data,
  output logic                 o_tx_ready,
  output logic                 o_serial,
  output logic                 o_tx_busy,
  output logic                 o_tx_done
);

  // ---------------------------------------------------------------- checks
  if (CLOCKS_PER_BIT < 2) begin : g_bad_clocks_per_bit
    $error("CLOCKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS) begin : g_bad_data_bits
    $error("DATA_BITS must be in 5..9");
  end
  if (PARITY != PARITY_NONE && PARITY != PARITY_ODD && PARITY != PARITY_EVEN) begin : g_bad_parity
    $error("PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("FIFO_DEPTH must be a power of 2 and >= 2");
  end

  localparam int CNT_W = $clog2(CLOCKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);

  // ---------------------------------------------------------------- signals
  tx_state_t            r_state,    w_state_nxt;
  logic [CNT_W-1:0]     r_cnt,      w_cnt_nxt;
  logic [IDX_W-1:0]     r_idx,      w_idx_nxt;
  logic                 r_stop_idx, w_stop_idx_nxt;
  logic [DATA_BITS-1:0] r_shift,    w_shift_nxt;
  logic                 r_par,      w_par_nxt;
  logic                 r_serial,   w_serial_nxt;
  logic                 r_done,     w_done_nxt;

  logic                     w_push;
  logic                     w_pop;
  logic                     w_load;
  logic                     w_full;
  logic                     w_empty;
  logic [DATA_BITS-1:0]     w_head;
  logic [MAX_DATA_BITS-1:0] w_head_ext;
  logic                     w_bit_end;

  // ---------------------------------------------------------------- FIFO
  // Ready ignores a same-cycle pop so a full FIFO never accepts.
  assign o_tx_ready = !w_full && !i_rst;
  assign w_push     = i_tx_valid && o_tx_ready;

  tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_data  (i_tx_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_head_ext                = '0;
    w_head_ext[DATA_BITS-1:0] = w_head;
  end

  // ---------------------------------------------------------------- FSM
  assign w_bit_end = (r_cnt == CNT_W'(CLOCKS_PER_BIT - 1));

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_idx_nxt      = r_idx;
    w_stop_idx_nxt = r_stop_idx;
    w_shift_nxt    = r_shift;
    w_par_nxt      = r_par;
    w_done_nxt     = 1'b0;
    w_load         = 1'b0;
    w_serial_nxt   = 1'b1;

    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_load = 1'b1;
        end
      end

      ST_START: begin
        if (w_bit_end) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_DATA;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (w_bit_end) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = r_shift >> 1;
          if (r_idx == IDX_W'(DATA_BITS - 1)) begin
            w_idx_nxt = '0;
            if (PARITY == PARITY_NONE) begin
              w_state_nxt = ST_STOP;
            end else begin
              w_state_nxt = ST_PARITY;
            end
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      ST_PARITY: begin
        if (w_bit_end) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_STOP;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      ST_STOP: begin
        if (w_bit_end) begin
          w_cnt_nxt = '0;
          if (r_stop_idx == 1'(STOP_BITS - 1)) begin
            w_stop_idx_nxt = 1'b0;
            w_done_nxt     = 1'b1;
            // Chain straight into the next frame when a word is waiting.
            if (!w_empty) begin
              w_load = 1'b1;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_stop_idx_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    if (w_load) begin
      w_state_nxt = ST_START;
      w_cnt_nxt   = '0;
      w_shift_nxt = w_head;
      w_par_nxt   = parity_bit(w_head_ext, PARITY);
    end

    // Serial is registered from the next state so it changes on the same
    // edge that the state does.
    case (w_state_nxt)
      ST_START:  w_serial_nxt = 1'b0;
      ST_DATA:   w_serial_nxt = w_shift_nxt[0];
      ST_PARITY: w_serial_nxt = w_par_nxt;
      default:   w_serial_nxt = 1'b1;
    endcase
  end

  assign w_pop = w_load;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_stop_idx <= 1'b0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_serial   <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_idx      <= w_idx_nxt;
      r_stop_idx <= w_stop_idx_nxt;
      r_shift    <= w_shift_nxt;
      r_par      <= w_par_nxt;
      r_serial   <= w_serial_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign o_serial  = r_serial;
  assign o_tx_done = r_done;
  assign o_tx_busy = !((r_state == ST_IDLE) && w_empty);

endmodule
`default_nettype wire

// File: tb/tb_configurable_transmitter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_configurable_transmitter
//  Description : Self-checking bench. Instance A: 8N1, instance B: 7E2,
//                instance C: 7O2, all with 4 clocks per bit. A serial-line
//                monitor decodes every frame against words queued on
//                acceptance; directed sequences cover reset, back-to-back
//                frames, FIFO full and mid-frame reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_configurable_transmitter;

  localparam int CPB = 4;

  logic clk;
  logic rst;

  logic       v_a, rdy_a, ser_a, busy_a, done_a;
  logic [7:0] d_a;
  logic       v_b, rdy_b, ser_b, busy_b, done_b;
  logic [6:0] d_b;
  logic       v_c, rdy_c, ser_c, busy_c, done_c;
  logic [6:0] d_c;

  configurable_transmitter #(.CLOCKS_PER_BIT(CPB)) u_a (
    .i_clk(clk), .i_rst(rst), .i_tx_valid(v_a), .i_tx_data(d_a),
    .o_tx_ready(rdy_a), .o_serial(ser_a), .o_tx_busy(busy_a), .o_tx_done(done_a));

  configurable_transmitter #(.CLOCKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_b (
    .i_clk(clk), .i_rst(rst), .i_tx_valid(v_b), .i_tx_data(d_b),
    .o_tx_ready(rdy_b), .o_serial(ser_b), .o_tx_busy(busy_b), .o_tx_done(done_b));

  configurable_transmitter #(.CLOCKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_c (
    .i_clk(clk), .i_rst(rst), .i_tx_valid(v_c), .i_tx_data(d_c),
    .o_tx_ready(rdy_c), .o_serial(ser_c), .o_tx_busy(busy_c), .o_tx_done(done_c));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- scoreboard
  logic [8:0]  qa[$];
  logic [8:0]  qb[$];
  logic [8:0]  qc[$];
  int          in_frame[3];
  int          cyc[3];
  int          flen[3];
  int          mism[3];
  int          exp_done[3];
  int          done_cnt[3];
  logic [12:0] expb[3];

  always @(posedge clk) begin
    if (!rst) begin
      if (v_a && rdy_a) qa.push_back({1'b0, d_a});
      if (v_b && rdy_b) qb.push_back({2'b0, d_b});
      if (v_c && rdy_c) qc.push_back({2'b0, d_c});
    end
  end

  // Expected line value for each bit slot: start, data LSB first, optional
  // parity, then stop bits (all remaining slots high).
  function automatic logic [12:0] build_frame(input logic [8:0] w, input int db, input int pm);
    logic [12:0] b;
    int ones;
    b    = '1;
    b[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < db; i++) begin
      b[1+i] = w[i];
      ones += int'(w[i]);
    end
    if (pm == 1) b[1+db] = ((ones % 2) == 0);
    if (pm == 2) b[1+db] = ((ones % 2) == 1);
    return b;
  endfunction

  task automatic mon(input int id, input logic ser, input logic dn);
    int db, pm, sb;
    logic [8:0] w;
    logic got;
    db = (id == 0) ? 8 : 7;
    pm = (id == 0) ? 0 : ((id == 1) ? 2 : 1);
    sb = (id == 0) ? 1 : 2;
    if (rst) begin
      in_frame[id] = 0;
      exp_done[id] = 0;
      return;
    end
    if (exp_done[id] != 0) begin
      checks++;
      if (dn !== 1'b1) begin
        errors++;
        $display("FAIL mon%0d done: got %b expected 1", id, dn);
      end else begin
        done_cnt[id]++;
      end
      exp_done[id] = 0;
    end else if (dn !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL mon%0d stray_done: got %b expected 0", id, dn);
    end
    if (in_frame[id] == 0 && ser === 1'b0) begin
      got = 1'b0;
      w   = '0;
      case (id)
        0: if (qa.size() > 0) begin w = qa.pop_front(); got = 1'b1; end
        1: if (qb.size() > 0) begin w = qb.pop_front(); got = 1'b1; end
        default: if (qc.size() > 0) begin w = qc.pop_front(); got = 1'b1; end
      endcase
      if (!got) begin
        checks++;
        errors++;
        $display("FAIL mon%0d unexpected_frame: got start bit expected idle", id);
      end
      expb[id]     = build_frame(w, db, pm);
      flen[id]     = (1 + db + ((pm != 0) ? 1 : 0) + sb) * CPB;
      in_frame[id] = 1;
      cyc[id]      = 0;
      mism[id]     = 0;
    end
    if (in_frame[id] != 0) begin
      if (ser !== expb[id][cyc[id] / CPB]) mism[id]++;
      if (cyc[id] == flen[id] - 1) begin
        checks++;
        if (mism[id] != 0) begin
          errors++;
          $display("FAIL mon%0d frame: got %0d bad cycles expected 0", id, mism[id]);
        end
        in_frame[id] = 0;
        exp_done[id] = 1;
      end else begin
        cyc[id]++;
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, ser_a, done_a);
    mon(1, ser_b, done_b);
    mon(2, ser_c, done_c);
  end

  // ---------------------------------------------------------------- helpers
  typedef struct {
    logic [7:0] data;
    logic [9:0] bits;   // bit 0 = start, bits 8:1 = data, bit 9 = stop
  } vec_t;

  vec_t vecs[5];

  task automatic wait_idle_a();
    for (int n = 0; n < 400; n++) begin
      if (busy_a === 1'b0) return;
      @(negedge clk);
    end
    chk("idle_timeout", busy_a, 0);
  endtask

  // Called at a negedge with A idle: send one word, check every cycle.
  task automatic send_a(input string tag, input logic [7:0] data, input logic [9:0] bits);
    logic acc;
    int   mis, early;
    v_a = 1'b1;
    d_a = data;
    @(posedge clk);
    acc = rdy_a;
    @(negedge clk);
    v_a = 1'b0;
    d_a = ~data;
    chk({tag, "_accept"}, acc, 1);
    mis   = 0;
    early = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (ser_a !== bits[(k-1)/CPB]) mis++;
      if (done_a !== 1'b0) early++;
      d_a = 8'($urandom);
    end
    chk({tag, "_bits"}, mis, 0);
    chk({tag, "_early_done"}, early, 0);
    @(negedge clk);
    chk({tag, "_done"}, done_a, 1);
    chk({tag, "_serial_idle"}, ser_a, 1);
    @(negedge clk);
    chk({tag, "_done_once"}, done_a, 0);
  endtask

  // ---------------------------------------------------------------- test
  initial begin
    vecs[0] = '{8'hA5, 10'b1_10100101_0};
    vecs[1] = '{8'h00, 10'b1_00000000_0};
    vecs[2] = '{8'hFF, 10'b1_11111111_0};
    vecs[3] = '{8'h3C, 10'b1_00111100_0};
    vecs[4] = '{8'h81, 10'b1_10000001_0};

    rst = 1'b1;
    v_a = 1'b0; d_a = '0;
    v_b = 1'b0; d_b = '0;
    v_c = 1'b0; d_c = '0;
    repeat (3) @(negedge clk);
    chk("rst_serial", ser_a, 1);
    chk("rst_ready", rdy_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    rst = 1'b0;

    // Table: first word is offered on the first edge after reset release.
    for (int v = 0; v < 5; v++) begin
      wait_idle_a();
      send_a($sformatf("vec%0d", v), vecs[v].data, vecs[v].bits);
    end

    // 7E2 / 7O2 with 0x55: four ones -> even parity 0, odd parity 1.
    begin
      int len_b, len_c;
      logic pb, pc, acc_b, acc_c;
      len_b = 0; len_c = 0; pb = 1'bx; pc = 1'bx;
      v_b = 1'b1; d_b = 7'h55;
      v_c = 1'b1; d_c = 7'h55;
      @(posedge clk);
      acc_b = rdy_b;
      acc_c = rdy_c;
      @(negedge clk);
      v_b = 1'b0; d_b = 7'h2A;
      v_c = 1'b0; d_c = 7'h2A;
      chk("b_accept", acc_b, 1);
      chk("c_accept", acc_c, 1);
      for (int k = 1; k <= 60; k++) begin
        @(negedge clk);
        if (k == 34) begin pb = ser_b; pc = ser_c; end
        if (done_b === 1'b1 && len_b == 0) len_b = k - 1;
        if (done_c === 1'b1 && len_c == 0) len_c = k - 1;
      end
      chk("b_parity", pb, 0);
      chk("c_parity", pc, 1);
      chk("b_frame_len", len_b, 44);
      chk("c_frame_len", len_c, 44);
    end

    // Burst of 6 words into a 4-deep FIFO with valid held high.
    begin
      logic [7:0] words[6];
      int   idx, dcount, last_done, acc6;
      logic [5:0] first_acc;
      logic a;
      words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
      words[3] = 8'h44; words[4] = 8'h55; words[5] = 8'h66;
      wait_idle_a();
      idx = 0; dcount = 0; last_done = 0; acc6 = 0; first_acc = '0;
      v_a = 1'b1;
      d_a = words[0];
      for (int e = 1; e <= 400; e++) begin
        @(posedge clk);
        a = v_a && rdy_a;
        @(negedge clk);
        if (e <= 6) first_acc[e-1] = a;
        if (a) begin
          idx++;
          if (idx == 6) begin
            acc6 = e;
            v_a  = 1'b0;
          end else begin
            d_a = words[idx];
          end
        end
        if (done_a === 1'b1) begin
          dcount++;
          last_done = e;
        end
        if (dcount == 6) break;
      end
      chk("burst_first_accepts", first_acc, 6'b011111);
      chk("burst_sixth_accept_edge", acc6, 43);
      chk("burst_done_count", dcount, 6);
      chk("burst_last_done_edge", last_done, 242);
    end

    // Reset during data bit 3 with two words still queued.
    begin
      int stray_done, stray_low;
      wait_idle_a();
      v_a = 1'b1;
      d_a = 8'h12;
      @(negedge clk);
      d_a = 8'h34;
      @(negedge clk);
      d_a = 8'h56;
      @(negedge clk);
      v_a = 1'b0;
      repeat (15) @(negedge clk);
      chk("pre_reset_bit3", ser_a, 0);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_serial", ser_a, 1);
      chk("abort_busy", busy_a, 0);
      chk("abort_ready", rdy_a, 0);
      chk("abort_done", done_a, 0);
      qa.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      stray_done = 0;
      stray_low  = 0;
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        if (done_a !== 1'b0) stray_done++;
        if (ser_a !== 1'b1) stray_low++;
      end
      chk("after_reset_no_done", stray_done, 0);
      chk("after_reset_line_idle", stray_low, 0);
      send_a("post_reset", 8'h3C, 10'b1_00111100_0);
    end

    wait_idle_a();
    repeat (4) @(negedge clk);
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    chk("qc_drained", qc.size(), 0);
    chk("a_frames_done", done_cnt[0], 12);
    chk("b_frames_done", done_cnt[1], 1);
    chk("c_frames_done", done_cnt[2], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
